tile_pick_input: RTL and testbench

- Input-side front end for the tile-matching game.
- Conditions the two raw active-low select pushbuttons: 2-FF synchronise, debounce, falling-edge detect.
- Encodes the one-hot slide-switch bank into a tile index.
- Sequences a first-tile / second-tile pick pair and hands the validated pair to the in-game FSM over a valid/ready handshake.
- Sits between the board pins (KEY[3:2], SW) and the in-game FSM. It is the producer end of the pick interface that FSM consumes.

---
 rtl/tile_pkg.sv | 15 +
 rtl/key_debounce.sv | 56 +++++
 rtl/tile_pick_input.sv | 153 +++++++++++++++
 tb/tb_tile_pick_input.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the tile-matching game: board geometry and the
// pick-sequencer state encoding used by both the input front end and the in-game FSM.
package tile_pkg;

    localparam int NUM_TILES = 10;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PICK1   = 2'd1,
        PICK2   = 2'd2,
        PRESENT = 2'd3
    } pick_state_t;

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-FF synchroniser, stability-count debouncer and
// a single-cycle pulse on each debounced press (1 -> 0 transition).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        // Any return to the debounced level restarts the stability count.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pulse_d = level_q & ~level_d;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/tile_pick_input.sv
// Input front end: debounced select keys plus one-hot switch bank drive a
// first/second tile pick sequencer that offers the pair over valid/ready.
module tile_pick_input
    import tile_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [1:0]           key_sel_n,
    input  logic [NUM_TILES-1:0] sw,
    input  logic                 pick_ready,
    output logic                 pick_valid,
    output logic [IDX_W-1:0]     pick_first,
    output logic [IDX_W-1:0]     pick_second,
    output logic                 first_held,
    output logic                 err_pulse
);

    localparam int ONES_W = $clog2(NUM_TILES + 1);

    // Handshake: the pair is transferred on a cycle with pick_valid & pick_ready;
    // pick_first/pick_second stay stable while pick_valid is high and not yet accepted.

    logic [1:0]           press;
    logic                 sel1, sel2;
    logic [NUM_TILES-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [ONES_W-1:0]    ones;
    logic                 choice_legal;
    logic [IDX_W-1:0]     choice_idx;

    pick_state_t          state_q, state_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     second_q, second_d;
    logic                 valid_q, valid_d;
    logic                 held_q, held_d;
    logic                 err_q, err_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel1 (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .key_n       (key_sel_n[0]),
        .press_pulse (press[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sel2 (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .key_n       (key_sel_n[1]),
        .press_pulse (press[1])
    );

    always_comb begin
        sw_s1_d    = sw;
        sw_s2_d    = sw_s1_q;
        ones       = '0;
        choice_idx = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (sw_s2_q[i]) begin
                ones       = ones + ONES_W'(1);
                choice_idx = IDX_W'(i);
            end
        end
        choice_legal = (ones == ONES_W'(1));
    end

    // Simultaneous presses: select1 wins and select2 is silently dropped.
    assign sel1 = press[0];
    assign sel2 = press[1] & ~press[0];

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        second_d = second_q;
        valid_d  = valid_q;
        held_d   = held_q;
        err_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            held_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = PICK1;
                PICK1: begin
                    if (sel1) begin
                        if (choice_legal) begin
                            first_d = choice_idx;
                            held_d  = 1'b1;
                            state_d = PICK2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (sel2) begin
                        err_d = 1'b1;
                    end
                end
                PICK2: begin
                    if (sel1) begin
                        if (choice_legal) first_d = choice_idx;
                        else              err_d   = 1'b1;
                    end else if (sel2) begin
                        if (choice_legal && (choice_idx != first_q)) begin
                            second_d = choice_idx;
                            valid_d  = 1'b1;
                            state_d  = PRESENT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (pick_ready) begin
                        valid_d = 1'b0;
                        held_d  = 1'b0;
                        state_d = PICK1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            state_q  <= IDLE;
            first_q  <= '0;
            second_q <= '0;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            state_q  <= state_d;
            first_q  <= first_d;
            second_q <= second_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
            err_q    <= err_d;
        end
    end

    assign pick_valid  = valid_q;
    assign pick_first  = first_q;
    assign pick_second = second_q;
    assign first_held  = held_q;
    assign err_pulse   = err_q;

endmodule

// File: tb/tb_tile_pick_input.sv
// Bench for tile_pick_input: directed scenarios then random presses, checked
// against a transaction-level model of the pick sequence.
module tb_tile_pick_input;

    localparam int DB = 4;
    localparam int M_IDLE = 0, M_PICK1 = 1, M_PICK2 = 2, M_PRESENT = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [1:0] key_sel_n;
    logic [9:0] sw;
    logic       pick_ready;
    logic       pick_valid;
    logic [3:0] pick_first;
    logic [3:0] pick_second;
    logic       first_held;
    logic       err_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    // Reference model: abstract pick sequence driven by whole press events.
    int         m_st;
    logic       m_en;
    logic       m_valid, m_held;
    logic [3:0] m_first, m_second;
    logic [9:0] exp_q[$];

    tile_pick_input #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .enable      (enable),
        .key_sel_n   (key_sel_n),
        .sw          (sw),
        .pick_ready  (pick_ready),
        .pick_valid  (pick_valid),
        .pick_first  (pick_first),
        .pick_second (pick_second),
        .first_held  (first_held),
        .err_pulse   (err_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) err_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_valid = 0; m_held = 0; m_first = 0; m_second = 0;
    endtask

    task automatic model_enable(input logic en);
        m_en = en;
        if (!en) begin
            m_st = M_IDLE; m_valid = 0; m_held = 0;
        end else if (m_st == M_IDLE) begin
            m_st = M_PICK1;
        end
    endtask

    task automatic model_accept();
        if (m_st == M_PRESENT) begin
            m_valid = 0; m_held = 0; m_st = M_PICK1;
        end
    endtask

    task automatic model_press(input logic [1:0] keys, input logic [9:0] s, output int exp_err);
        logic       legal;
        logic [3:0] idx;
        legal   = ($countones(s) == 1);
        idx     = legal ? 4'($clog2(s)) : 4'd0;
        exp_err = 0;
        if (keys[0]) begin
            if (m_st == M_PICK1) begin
                if (legal) begin m_first = idx; m_held = 1; m_st = M_PICK2; end
                else exp_err = 1;
            end else if (m_st == M_PICK2) begin
                if (legal) m_first = idx;
                else exp_err = 1;
            end
        end else if (keys[1]) begin
            if (m_st == M_PICK1) exp_err = 1;
            else if (m_st == M_PICK2) begin
                if (legal && idx != m_first) begin
                    m_second = idx; m_valid = 1; m_st = M_PRESENT;
                end else exp_err = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [9:0] e;
        exp_q.push_back({m_valid, m_held, m_first, m_second});
        e = exp_q.pop_front();
        check({tag, ".valid"},  pick_valid,  e[9]);
        check({tag, ".held"},   first_held,  e[8]);
        check({tag, ".first"},  pick_first,  e[7:4]);
        check({tag, ".second"}, pick_second, e[3:0]);
    endtask

    task automatic do_press(input string tag, input logic [1:0] keys, input logic [9:0] s);
        int exp_err;
        @(negedge clk);
        sw = s;
        repeat (3) @(negedge clk);
        err_seen  = 0;
        key_sel_n = ~keys;
        repeat (10) @(negedge clk);
        key_sel_n = 2'b11;
        repeat (10) @(negedge clk);
        model_press(keys, s, exp_err);
        check({tag, ".err"}, err_seen, exp_err);
        check_outputs(tag);
    endtask

    task automatic do_bounce(input string tag, input logic [1:0] keys, input int len);
        @(negedge clk);
        err_seen  = 0;
        key_sel_n = ~keys;
        repeat (len) @(negedge clk);
        key_sel_n = 2'b11;
        repeat (12) @(negedge clk);
        check({tag, ".err"}, err_seen, 0);
        check_outputs(tag);
    endtask

    task automatic do_accept(input string tag);
        @(negedge clk);
        pick_ready = 1'b1;
        @(negedge clk);
        pick_ready = 1'b0;
        model_accept();
        check_outputs(tag);
    endtask

    task automatic do_enable_drop(input string tag);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        model_enable(1'b0);
        check_outputs({tag, ".off"});
        enable = 1'b1;
        repeat (2) @(negedge clk);
        model_enable(1'b1);
        check_outputs({tag, ".on"});
    endtask

    initial begin
        logic [9:0] s;
        int         r;
        resetn = 0; enable = 0; key_sel_n = 2'b11; sw = '0; pick_ready = 0;
        m_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.err", err_pulse, 0);
        resetn = 1;
        @(negedge clk);
        enable = 1;
        repeat (2) @(negedge clk);
        model_enable(1'b1);

        sw = 10'h004;
        repeat (3) @(negedge clk);
        do_bounce("bounce3", 2'b01, 3);
        do_press("illegal1", 2'b01, 10'h00C);
        do_press("first2", 2'b01, 10'h004);
        do_press("second9", 2'b10, 10'h200);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_outputs("stable");
        end
        do_accept("accept");

        do_press("first2b", 2'b01, 10'h004);
        do_press("same_tile", 2'b10, 10'h004);
        do_press("repick4", 2'b01, 10'h010);
        do_press("both", 2'b11, 10'h100);
        do_press("second1", 2'b10, 10'h002);
        do_press("present_ign", 2'b01, 10'h020);
        do_enable_drop("abort");

        // Reset in the middle of a debounce while a first tile is held.
        do_press("pre_rst", 2'b01, 10'h040);
        @(negedge clk);
        sw = 10'h008;
        key_sel_n = 2'b01;
        repeat (3) @(negedge clk);
        #2 resetn = 0;
        #1;
        model_reset();
        check_outputs("async_rst");
        key_sel_n = 2'b11;
        repeat (3) @(negedge clk);
        err_seen = 0;
        resetn = 1;
        repeat (20) @(negedge clk);
        model_enable(1'b1);
        check("rst_release.err", err_seen, 0);
        check_outputs("rst_release");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if ($urandom_range(0, 9) < 7) s = 10'd1 << $urandom_range(0, 9);
                else s = 10'($urandom_range(0, 1023));
                do_press("rnd_press", 2'($urandom_range(1, 3)), s);
            end else if (r < 8) begin
                do_accept("rnd_accept");
            end else if (r == 8) begin
                do_bounce("rnd_bounce", 2'($urandom_range(1, 3)), $urandom_range(1, 3));
            end else begin
                do_enable_drop("rnd_enable");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
